// File: rtl/uart_rx_cmd_decoder.sv
// uart_rx_cmd_decoder
//
// Sits behind the UART receiver. It assembles multi-byte command frames from
// received bytes and issues single-cycle register-file and ALU strobes.
// Malformed, corrupted or stalled frames are aborted and the cause reported.
//
// Frames (first byte is the opcode, decoded in IDLE):
//   AA addr data   register write  -> wr_en
//   BB addr        register read   -> rd_en
//   CC a b fun     ALU with operands -> alu_en
//   DD fun         ALU, previous operands -> alu_en
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rx_data_valid           one-cycle byte-available pulse
//   rx_data                 received byte
//   rx_par_error            parity error for the current byte
//   rx_frame_error          start/stop error for the current byte
//   wr_en, rd_en, alu_en    one-cycle command strobes (mutually exclusive)
//   addr, wr_data           register address / write data, held
//   alu_op_a, alu_op_b      ALU operands, held
//   alu_fun                 ALU function, held
//   cmd_busy                high while a frame is in progress
//   cmd_error               one-cycle abort pulse
//   err_code                01 byte error, 10 unknown opcode, 11 timeout; held
//   good_cmd_cnt, err_cnt   saturating statistics counters
//
// Build option: define UART_RX_CMD_STATS_EN to implement the statistics
// counters; otherwise good_cmd_cnt and err_cnt are constant zero.

module uart_rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_data_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_par_error,
  input  logic                  rx_frame_error,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  alu_en,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output logic [3:0]            alu_fun,
  output logic                  cmd_busy,
  output logic                  cmd_error,
  output logic [1:0]            err_code,
  output logic [7:0]            good_cmd_cnt,
  output logic [7:0]            err_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] ALU_A   = 3'd4;
  localparam logic [2:0] ALU_B   = 3'd5;
  localparam logic [2:0] ALU_FUN = 3'd6;

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

  localparam logic [1:0] ERR_BYTE    = 2'b01;
  localparam logic [1:0] ERR_OPCODE  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic [2:0]            state, state_nxt;
  logic [TW-1:0]         tmo_cnt, tmo_nxt;
  logic                  wr_en_nxt, rd_en_nxt, alu_en_nxt, err_nxt;
  logic [1:0]            code_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt, op_a_nxt, op_b_nxt;
  logic [3:0]            fun_nxt;

  always_comb begin
    state_nxt   = state;
    tmo_nxt     = tmo_cnt;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    alu_en_nxt  = 1'b0;
    err_nxt     = 1'b0;
    code_nxt    = err_code;
    addr_nxt    = addr;
    wr_data_nxt = wr_data;
    op_a_nxt    = alu_op_a;
    op_b_nxt    = alu_op_b;
    fun_nxt     = alu_fun;

    if (rx_data_valid) begin
      // Any accepted byte restarts the inter-byte timeout, and a byte landing
      // on the expiry cycle wins over the timeout.
      tmo_nxt = '0;
      if (rx_par_error || rx_frame_error) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
        code_nxt  = ERR_BYTE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_data == OP_WR)           state_nxt = WR_ADDR;
            else if (rx_data == OP_RD)      state_nxt = RD_ADDR;
            else if (rx_data == OP_ALU)     state_nxt = ALU_A;
            else if (rx_data == OP_ALU_NO)  state_nxt = ALU_FUN;
            else begin
              err_nxt  = 1'b1;
              code_nxt = ERR_OPCODE;
            end
          end
          WR_ADDR: begin
            addr_nxt  = rx_data[ADDR_WIDTH-1:0];
            state_nxt = WR_DATA;
          end
          WR_DATA: begin
            wr_data_nxt = rx_data;
            wr_en_nxt   = 1'b1;
            state_nxt   = IDLE;
          end
          RD_ADDR: begin
            addr_nxt  = rx_data[ADDR_WIDTH-1:0];
            rd_en_nxt = 1'b1;
            state_nxt = IDLE;
          end
          ALU_A: begin
            op_a_nxt  = rx_data;
            state_nxt = ALU_B;
          end
          ALU_B: begin
            op_b_nxt  = rx_data;
            state_nxt = ALU_FUN;
          end
          ALU_FUN: begin
            fun_nxt    = rx_data[3:0];
            alu_en_nxt = 1'b1;
            state_nxt  = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nxt = IDLE;
        tmo_nxt   = '0;
        err_nxt   = 1'b1;
        code_nxt  = ERR_TIMEOUT;
      end else begin
        tmo_nxt = tmo_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      alu_en    <= 1'b0;
      cmd_error <= 1'b0;
      cmd_busy  <= 1'b0;
      err_code  <= '0;
      addr      <= '0;
      wr_data   <= '0;
      alu_op_a  <= '0;
      alu_op_b  <= '0;
      alu_fun   <= '0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_nxt;
      wr_en     <= wr_en_nxt;
      rd_en     <= rd_en_nxt;
      alu_en    <= alu_en_nxt;
      cmd_error <= err_nxt;
      // Registered copy of the busy decode so the output comes straight from a flop.
      cmd_busy  <= (state_nxt != IDLE);
      err_code  <= code_nxt;
      addr      <= addr_nxt;
      wr_data   <= wr_data_nxt;
      alu_op_a  <= op_a_nxt;
      alu_op_b  <= op_b_nxt;
      alu_fun   <= fun_nxt;
    end
  end

`ifdef UART_RX_CMD_STATS_EN
  logic [7:0] good_q, err_q;

  // Counters follow the registered strobes, so they lag the pulse by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= 8'd0;
      err_q  <= 8'd0;
    end else begin
      if ((wr_en || rd_en || alu_en) && good_q != 8'hFF) good_q <= good_q + 8'd1;
      if (cmd_error && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign good_cmd_cnt = good_q;
  assign err_cnt      = err_q;
`else
  assign good_cmd_cnt = 8'd0;
  assign err_cnt      = 8'd0;
`endif

endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver.
- Consumes received bytes and their parity/framing error flags, and assembles multi-byte command frames.
- Issues single-cycle register-file write/read strobes and ALU operation strobes to the system controller side.
- Aborts malformed, corrupted or stalled frames and reports the cause.

Parameters:
- DATA_WIDTH, 8, width of received byte, register data and ALU operands.
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
- TIMEOUT_CYCLES, 1024, idle clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-high
- rx_data_valid  input  1  one-cycle pulse, byte available
- rx_data  input  DATA_WIDTH  received byte, valid with rx_data_valid
- rx_par_error  input  1  parity error for current byte, valid with rx_data_valid
- rx_frame_error  input  1  start/stop error for current byte, valid with rx_data_valid
- wr_en  output  1  register write strobe, one cycle
- rd_en  output  1  register read strobe, one cycle
- addr  output  ADDR_WIDTH  register address, held until next command
- wr_data  output  DATA_WIDTH  register write data, held
- alu_en  output  1  ALU execute strobe, one cycle
- alu_op_a  output  DATA_WIDTH  ALU operand A, held
- alu_op_b  output  DATA_WIDTH  ALU operand B, held
- alu_fun  output  4  ALU function, from rx_data[3:0], held
- cmd_busy  output  1  high while state is not IDLE
- cmd_error  output  1  one-cycle abort pulse
- err_code  output  2  01 byte error, 10 unknown opcode, 11 timeout; held until next error
- good_cmd_cnt  output  8  completed-command counter (optional feature)
- err_cnt  output  8  error counter (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-frame discards the partial frame with no strobe and no cmd_error.
- Byte acceptance: a byte is accepted only on the cycle rx_data_valid=1. All outputs are registered; every strobe rises the cycle after the accepting edge and lasts exactly one cycle.
- Opcodes, decoded in IDLE:
  - 0xAA register write: IDLE -> WR_ADDR -> WR_DATA -> IDLE. The data byte loads wr_data and pulses wr_en.
  - 0xBB register read: IDLE -> RD_ADDR -> IDLE. The address byte loads addr and pulses rd_en.
  - 0xCC ALU with operands: IDLE -> ALU_A -> ALU_B -> ALU_FUN -> IDLE. The function byte loads alu_fun and pulses alu_en.
  - 0xDD ALU no operands: IDLE -> ALU_FUN -> IDLE. alu_op_a and alu_op_b keep their previous values.
- Address byte: addr = rx_data[ADDR_WIDTH-1:0]; upper bits ignored, no error.
- Unknown opcode in IDLE: stay IDLE, pulse cmd_error, err_code=10.
- Byte error: a byte with rx_par_error or rx_frame_error in any state is discarded. Return to IDLE, pulse cmd_error, err_code=01, no command strobe. This check takes priority over opcode decode.
- Timeout: the counter runs only when state is not IDLE and clears on each accepted byte. When it reaches TIMEOUT_CYCLES-1: go IDLE, pulse cmd_error, err_code=11.
- Timeout vs byte: rx_data_valid in the same cycle as timeout expiry means the byte is processed and the timeout is suppressed.
- Back-to-back frames: a new opcode may arrive the cycle after the final byte of the previous frame; no dead cycle is required.
- Strobe exclusivity: wr_en, rd_en and alu_en are mutually exclusive. cmd_error never coincides with a command strobe.

Optional Feature:
- Macro: UART_RX_CMD_STATS_EN.
- Defined:
  - good_cmd_cnt increments on every wr_en, rd_en or alu_en pulse.
  - err_cnt increments on every cmd_error pulse.
  - Both counters are 8-bit, saturate at 0xFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Write: bytes AA,13,5C -> one-cycle wr_en with addr=3, wr_data=0x5C; cmd_busy low after.
- Read then ALU:
  - bytes BB,07 -> rd_en with addr=7.
  - bytes CC,09,04,02 -> alu_en with op_a=9, op_b=4, fun=2.
  - bytes DD,05 -> alu_en with op_a=9, op_b=4, fun=5.
- Unknown opcode: byte 3F -> cmd_error, err_code=10. Then AA,01,FF -> wr_en, addr=1, wr_data=0xFF.
- Byte error: AA,02 then a byte with rx_par_error=1 -> cmd_error, err_code=01, no wr_en, state IDLE.
- Timeout: AA then no byte for 1024 cycles -> cmd_error, err_code=11.
  - Repeat with a byte landing on the expiry cycle -> no error, frame continues.
- Reset mid-frame, and stats:
  - CC,01 then reset -> all outputs 0, no strobe.
  - With UART_RX_CMD_STATS_EN: 300 good writes -> good_cmd_cnt=0xFF (saturated).
